// File: rtl/pc_ras_unit_if.sv
// pc_ras_unit_if
//   Bundles the fetch-control inputs and the PC/RAS status outputs of the
//   IF-stage program counter so the unit and its driver share one port.
//   master: pipeline side (drives stall/branch/jump/call/ret/exception,
//           observes pc_out, epc_out, redirect and RAS status).
//   slave : the pc_ras_unit itself.
interface pc_ras_unit_if #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RAS_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic              write_enable;
    logic              pc_src;
    logic [ADDR_W-1:0] branch_address;
    logic              jump;
    logic [ADDR_W-1:0] jump_address;
    logic              call;
    logic [ADDR_W-1:0] link_address;
    logic              ret;
    logic              exception;
    logic [ADDR_W-1:0] exc_pc;

    logic [ADDR_W-1:0] pc_out;
    logic [ADDR_W-1:0] epc_out;
    logic              redirect;
    logic [CNT_W-1:0]  ras_count;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_overflow;

    modport master (
        output write_enable, pc_src, branch_address, jump, jump_address,
               call, link_address, ret, exception, exc_pc,
        input  pc_out, epc_out, redirect, ras_count, ras_empty, ras_full,
               ras_overflow
    );

    modport slave (
        input  write_enable, pc_src, branch_address, jump, jump_address,
               call, link_address, ret, exception, exc_pc,
        output pc_out, epc_out, redirect, ras_count, ras_empty, ras_full,
               ras_overflow
    );
endinterface

// File: rtl/pc_ras_unit.sv
// pc_ras_unit
//   IF-stage program counter with exception redirect/EPC capture, a circular
//   return-address stack for call/return prediction and a registered
//   redirect flag used to flush the pipeline.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - pc_ras_unit_if.slave: control inputs (write_enable, pc_src,
//           branch_address, jump, jump_address, call, link_address, ret,
//           exception, exc_pc) and outputs (pc_out, epc_out, redirect,
//           ras_count, ras_empty, ras_full, ras_overflow)
module pc_ras_unit #(
    parameter int unsigned          ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]    RESET_VECTOR = '0,
    parameter logic [31:0]          EXC_VECTOR   = 32'h0000_0040,
    parameter int unsigned          STEP         = 1,
    parameter int unsigned          RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    pc_ras_unit_if.slave     bus
);
    localparam int unsigned       CNT_W      = $clog2(RAS_DEPTH + 1);
    localparam int unsigned       PTR_W      = $clog2(RAS_DEPTH);
    localparam logic [ADDR_W-1:0] EXC_TARGET = ADDR_W'(EXC_VECTOR);
    localparam logic [ADDR_W-1:0] STEP_INC   = ADDR_W'(STEP);
    localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(RAS_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(RAS_DEPTH - 1);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] epc;
    logic              redirect_q;
    logic [ADDR_W-1:0] stack [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    logic [PTR_W-1:0]  top_idx;
    logic [PTR_W-1:0]  ptr_inc;
    logic              ras_nonempty;

    logic [ADDR_W-1:0] pc_next;
    logic              redirect_next;
    logic              capture_epc;
    logic              do_push;
    logic              do_pop;
    logic              do_replace;

    // Circular pointer arithmetic written out explicitly so that depths
    // that are not a power of two still wrap correctly. Top of stack is ptr-1.
    assign top_idx      = (ptr == '0) ? PTR_LAST : ptr - 1'b1;
    assign ptr_inc      = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    assign ras_nonempty = (count != '0);

    // Next-PC selection by strict priority: exception, resolved branch,
    // then ID-stage jump/call/ret (only when fetch may advance), then the
    // sequential step. Branch and exception squash the younger ID events,
    // so they never touch the RAS.
    always_comb begin
        pc_next       = pc;
        redirect_next = 1'b0;
        capture_epc   = 1'b0;
        do_push       = 1'b0;
        do_pop        = 1'b0;
        do_replace    = 1'b0;
        if (bus.exception) begin
            pc_next       = EXC_TARGET;
            redirect_next = 1'b1;
            capture_epc   = 1'b1;
        end else if (bus.pc_src) begin
            pc_next       = bus.branch_address;
            redirect_next = 1'b1;
        end else if (bus.write_enable && (bus.jump || bus.call || bus.ret)) begin
            redirect_next = 1'b1;
            if (bus.call && bus.ret) begin
                // A call that is also a return swaps the top entry; on an
                // empty stack it degenerates into a plain push.
                if (ras_nonempty) begin
                    pc_next    = stack[top_idx];
                    do_replace = 1'b1;
                end else begin
                    pc_next = bus.jump_address;
                    do_push = 1'b1;
                end
            end else if (bus.call) begin
                pc_next = bus.jump_address;
                do_push = 1'b1;
            end else if (bus.ret) begin
                if (ras_nonempty) begin
                    pc_next = stack[top_idx];
                    do_pop  = 1'b1;
                end else begin
                    pc_next = bus.jump_address;
                end
            end else begin
                pc_next = bus.jump_address;
            end
        end else if (bus.write_enable) begin
            pc_next = pc + STEP_INC;
        end
    end

    // PC, EPC, redirect flag and RAS bookkeeping. A push while full
    // overwrites the oldest entry, keeps the count saturated and latches
    // the sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_VECTOR;
            epc        <= '0;
            redirect_q <= 1'b0;
            ptr        <= '0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            pc         <= pc_next;
            redirect_q <= redirect_next;
            if (capture_epc) begin
                epc <= bus.exc_pc;
            end
            if (do_push) begin
                ptr <= ptr_inc;
                if (count == CNT_MAX) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end else if (do_pop) begin
                ptr   <= top_idx;
                count <= count - 1'b1;
            end
        end
    end

    // RAS storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack[ptr] <= bus.link_address;
        end else if (do_replace) begin
            stack[top_idx] <= bus.link_address;
        end
    end

    assign bus.pc_out       = pc;
    assign bus.epc_out      = epc;
    assign bus.redirect     = redirect_q;
    assign bus.ras_count    = count;
    assign bus.ras_empty    = (count == '0);
    assign bus.ras_full     = (count == CNT_MAX);
    assign bus.ras_overflow = overflow;
endmodule
